ovl_window_seq_ctrl: RTL and testbench

//   Sequencer that drives an ovl_window checker's start_event / test_expr / end_event inputs.

---
 rtl/ovl_window_seq_ctrl_if.sv | 31 +++
 rtl/ovl_window_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ovl_window_seq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ovl_window_seq_ctrl_if.sv
// Handshake/stimulus bundle between a test driver and the ovl_window sequencer.
// The driver owns the request/config signals; the sequencer owns the checker-facing outputs.
interface ovl_window_seq_ctrl_if #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned CNT_W = 8
);
    logic             enable;
    logic             go;
    logic             abort;
    logic [LEN_W-1:0] win_len;
    logic [LEN_W-1:0] gap_len;
    logic [CNT_W-1:0] num_windows;
    logic             inject_drop;

    logic             start_event;
    logic             window;
    logic             end_event;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] win_cnt;

    modport master (
        output enable, go, abort, win_len, gap_len, num_windows, inject_drop,
        input  start_event, window, end_event, busy, done, win_cnt
    );

    modport slave (
        input  enable, go, abort, win_len, gap_len, num_windows, inject_drop,
        output start_event, window, end_event, busy, done, win_cnt
    );
endinterface

// File: rtl/ovl_window_seq_ctrl.sv
// Generates N programmable start/window/end sequences for an ovl_window checker,
// with an optional one-cycle window drop to exercise the checker's fail path.
module ovl_window_seq_ctrl #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input logic                    i_clock,
    input logic                    i_reset_n,
    ovl_window_seq_ctrl_if.slave   io_bus
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StOpen,
        StClose,
        StGap
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] w_win_cnt_d;
    logic [CNT_W-1:0] w_win_cnt_inc;

    logic [LEN_W-1:0] r_win_len;
    logic [LEN_W-1:0] w_win_len_d;
    logic [LEN_W-1:0] r_gap_len;
    logic [LEN_W-1:0] w_gap_len_d;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] w_num_d;
    logic             r_drop;
    logic             w_drop_d;
    logic [LEN_W-1:0] w_open_len;

    logic             r_start;
    logic             w_start_d;
    logic             r_window;
    logic             w_window_d;
    logic             r_end;
    logic             w_end_d;
    logic             r_busy;
    logic             w_busy_d;
    logic             r_done;
    logic             w_done_d;

    logic             w_seq_done;
    logic             w_first_open;
    logic             w_hold;

    assign w_win_cnt_inc = r_win_cnt + CNT_W'(1);
    // A zero-length window still gets one OPEN cycle.
    assign w_open_len    = (r_win_len == '0) ? LEN_W'(1) : r_win_len;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_win_cnt_d  = r_win_cnt;
        w_win_len_d  = r_win_len;
        w_gap_len_d  = r_gap_len;
        w_num_d      = r_num;
        w_drop_d     = r_drop;
        w_seq_done   = 1'b0;
        w_first_open = 1'b0;
        w_hold       = 1'b0;

        if (io_bus.abort) begin
            w_state_d = StIdle;
        end else if (!io_bus.enable) begin
            w_hold = 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (io_bus.go) begin
                        if (io_bus.num_windows != '0) begin
                            w_state_d   = StStart;
                            w_win_cnt_d = '0;
                            w_win_len_d = io_bus.win_len;
                            w_gap_len_d = io_bus.gap_len;
                            w_num_d     = io_bus.num_windows;
                            w_drop_d    = io_bus.inject_drop;
                        end else begin
                            w_seq_done = 1'b1;
                        end
                    end
                end
                StStart: begin
                    w_state_d    = StOpen;
                    w_cnt_d      = w_open_len;
                    w_first_open = 1'b1;
                end
                StOpen: begin
                    if (r_cnt <= LEN_W'(1)) begin
                        w_state_d = StClose;
                    end else begin
                        w_cnt_d = r_cnt - LEN_W'(1);
                    end
                end
                StClose: begin
                    w_win_cnt_d = w_win_cnt_inc;
                    if (w_win_cnt_inc == r_num) begin
                        w_state_d  = StIdle;
                        w_seq_done = 1'b1;
                    end else if (r_gap_len == '0) begin
                        w_state_d = StStart;
                    end else begin
                        w_state_d = StGap;
                        w_cnt_d   = r_gap_len;
                    end
                end
                StGap: begin
                    if (r_cnt <= LEN_W'(1)) begin
                        w_state_d = StStart;
                    end else begin
                        w_cnt_d = r_cnt - LEN_W'(1);
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end

        // Outputs are registered copies of the next state, so they line up with r_state.
        if (w_hold) begin
            w_start_d  = r_start;
            w_window_d = r_window;
            w_end_d    = r_end;
            w_busy_d   = r_busy;
            w_done_d   = r_done;
        end else begin
            w_start_d  = (w_state_d == StStart);
            w_window_d = ((w_state_d == StOpen) &&
                          !(w_first_open && r_drop && (r_win_cnt == '0))) ||
                         (w_state_d == StClose);
            w_end_d    = (w_state_d == StClose);
            w_busy_d   = (w_state_d != StIdle);
            w_done_d   = w_seq_done;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_win_cnt <= '0;
            r_win_len <= '0;
            r_gap_len <= '0;
            r_num     <= '0;
            r_drop    <= 1'b0;
            r_start   <= 1'b0;
            r_window  <= 1'b0;
            r_end     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_win_cnt <= w_win_cnt_d;
            r_win_len <= w_win_len_d;
            r_gap_len <= w_gap_len_d;
            r_num     <= w_num_d;
            r_drop    <= w_drop_d;
            r_start   <= w_start_d;
            r_window  <= w_window_d;
            r_end     <= w_end_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
        end
    end

    assign io_bus.start_event = r_start;
    assign io_bus.window      = r_window;
    assign io_bus.end_event   = r_end;
    assign io_bus.busy        = r_busy;
    assign io_bus.done        = r_done;
    assign io_bus.win_cnt     = r_win_cnt;

endmodule

// File: tb/tb_ovl_window_seq_ctrl.sv
// Directed bench for ovl_window_seq_ctrl: per-cycle traces against hand-derived patterns,
// plus a minimal ovl_window-style checker model counting window drops.
module tb_ovl_window_seq_ctrl;

    logic clk;
    logic rst_n;

    ovl_window_seq_ctrl_if #(.LEN_W(8), .CNT_W(8)) bus ();

    ovl_window_seq_ctrl #(.LEN_W(8), .CNT_W(8)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .io_bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int chk_err;
    logic chk_in;
    logic [31:0] tr_s, tr_w, tr_e, tr_d, tr_b;

    function automatic logic [31:0] mask(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // One clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (chk_in && !bus.window) chk_err++;
        if (bus.start_event) chk_in = 1'b1;
        if (bus.end_event) chk_in = 1'b0;
    endtask

    // Caller sets go=1 in cycle 0; config inputs are scrambled after go to prove latching.
    task automatic run_trace(input int n, input int pause_at, input int pause_len);
        tr_s = '0; tr_w = '0; tr_e = '0; tr_d = '0; tr_b = '0;
        chk_in = 1'b0;
        chk_err = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            if (k == 1) begin
                bus.go          = 1'b0;
                bus.win_len     = 8'd9;
                bus.gap_len     = 8'd7;
                bus.num_windows = 8'd1;
                bus.inject_drop = ~bus.inject_drop;
            end
            if (k == pause_at) bus.enable = 1'b0;
            if (k == pause_at + pause_len) bus.enable = 1'b1;
            tr_s[k] = bus.start_event;
            tr_w[k] = bus.window;
            tr_e[k] = bus.end_event;
            tr_d[k] = bus.done;
            tr_b[k] = bus.busy;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.go = 1'b1;
        bus.enable = 1'b1;
        bus.num_windows = 8'd2;
        bus.win_len = 8'd1;
        repeat (5) tick();
        n_checks++;
        if ({bus.start_event, bus.window, bus.end_event} !== 3'b000) begin
            $display("FAIL reset_events: got %b expected 000",
                     {bus.start_event, bus.window, bus.end_event});
            n_errors++;
        end
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            $display("FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done});
            n_errors++;
        end
        n_checks++;
        if (bus.win_cnt !== 8'd0) begin
            $display("FAIL reset_win_cnt: got %0d expected 0", bus.win_cnt);
            n_errors++;
        end
        rst_n = 1'b1;
        bus.go = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({bus.busy, bus.start_event, bus.done} !== 3'b000) begin
            $display("FAIL post_reset_idle: got %b expected 000",
                     {bus.busy, bus.start_event, bus.done});
            n_errors++;
        end
    endtask

    task automatic test_basic();
        bus.win_len = 8'd5; bus.gap_len = 8'd1; bus.num_windows = 8'd2;
        bus.inject_drop = 1'b0; bus.go = 1'b1;
        run_trace(20, 99, 0);
        n_checks++;
        if (tr_s !== (mask(1, 1) | mask(9, 9))) begin
            $display("FAIL basic_start: got %h expected %h", tr_s, mask(1, 1) | mask(9, 9));
            n_errors++;
        end
        n_checks++;
        if (tr_w !== (mask(2, 7) | mask(10, 15))) begin
            $display("FAIL basic_window: got %h expected %h", tr_w, mask(2, 7) | mask(10, 15));
            n_errors++;
        end
        n_checks++;
        if (tr_e !== (mask(7, 7) | mask(15, 15))) begin
            $display("FAIL basic_end: got %h expected %h", tr_e, mask(7, 7) | mask(15, 15));
            n_errors++;
        end
        n_checks++;
        if (tr_d !== mask(16, 16)) begin
            $display("FAIL basic_done: got %h expected %h", tr_d, mask(16, 16));
            n_errors++;
        end
        n_checks++;
        if (tr_b !== mask(1, 15)) begin
            $display("FAIL basic_busy: got %h expected %h", tr_b, mask(1, 15));
            n_errors++;
        end
        n_checks++;
        if (bus.win_cnt !== 8'd2) begin
            $display("FAIL basic_win_cnt: got %0d expected 2", bus.win_cnt);
            n_errors++;
        end
        n_checks++;
        if (chk_err !== 0) begin
            $display("FAIL basic_checker: got %0d expected 0", chk_err);
            n_errors++;
        end
    endtask

    task automatic test_back_to_back();
        bus.win_len = 8'd0; bus.gap_len = 8'd0; bus.num_windows = 8'd3;
        bus.inject_drop = 1'b0; bus.go = 1'b1;
        run_trace(14, 99, 0);
        n_checks++;
        if (tr_s !== (mask(1, 1) | mask(4, 4) | mask(7, 7))) begin
            $display("FAIL b2b_start: got %h expected %h", tr_s,
                     mask(1, 1) | mask(4, 4) | mask(7, 7));
            n_errors++;
        end
        n_checks++;
        if (tr_w !== (mask(2, 3) | mask(5, 6) | mask(8, 9))) begin
            $display("FAIL b2b_window: got %h expected %h", tr_w,
                     mask(2, 3) | mask(5, 6) | mask(8, 9));
            n_errors++;
        end
        n_checks++;
        if (tr_e !== (mask(3, 3) | mask(6, 6) | mask(9, 9))) begin
            $display("FAIL b2b_end: got %h expected %h", tr_e,
                     mask(3, 3) | mask(6, 6) | mask(9, 9));
            n_errors++;
        end
        n_checks++;
        if ({tr_d, tr_b} !== {mask(10, 10), mask(1, 9)}) begin
            $display("FAIL b2b_done_busy: got %h/%h expected %h/%h", tr_d, tr_b,
                     mask(10, 10), mask(1, 9));
            n_errors++;
        end
        n_checks++;
        if (bus.win_cnt !== 8'd3) begin
            $display("FAIL b2b_win_cnt: got %0d expected 3", bus.win_cnt);
            n_errors++;
        end
        n_checks++;
        if (chk_err !== 0) begin
            $display("FAIL b2b_checker: got %0d expected 0", chk_err);
            n_errors++;
        end
    endtask

    task automatic test_drop();
        bus.win_len = 8'd4; bus.gap_len = 8'd0; bus.num_windows = 8'd1;
        bus.inject_drop = 1'b1; bus.go = 1'b1;
        run_trace(10, 99, 0);
        n_checks++;
        if (tr_s !== mask(1, 1)) begin
            $display("FAIL drop_start: got %h expected %h", tr_s, mask(1, 1));
            n_errors++;
        end
        n_checks++;
        if (tr_w !== mask(3, 6)) begin
            $display("FAIL drop_window: got %h expected %h", tr_w, mask(3, 6));
            n_errors++;
        end
        n_checks++;
        if ({tr_e, tr_d} !== {mask(6, 6), mask(7, 7)}) begin
            $display("FAIL drop_end_done: got %h/%h expected %h/%h", tr_e, tr_d,
                     mask(6, 6), mask(7, 7));
            n_errors++;
        end
        n_checks++;
        if (chk_err !== 1) begin
            $display("FAIL drop_checker: got %0d expected 1", chk_err);
            n_errors++;
        end
        n_checks++;
        if (bus.win_cnt !== 8'd1) begin
            $display("FAIL drop_win_cnt: got %0d expected 1", bus.win_cnt);
            n_errors++;
        end
    endtask

    task automatic test_abort();
        logic seen_done;
        bus.win_len = 8'd3; bus.gap_len = 8'd2; bus.num_windows = 8'd3;
        bus.inject_drop = 1'b0; bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        repeat (8) tick();
        // cycle 9: first OPEN cycle of window 1
        n_checks++;
        if ({bus.window, bus.busy, bus.win_cnt} !== {2'b11, 8'd1}) begin
            $display("FAIL abort_pre_state: got %b/%b/%0d expected 1/1/1",
                     bus.window, bus.busy, bus.win_cnt);
            n_errors++;
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++;
        if ({bus.start_event, bus.window, bus.end_event, bus.busy, bus.done} !== 5'b00000) begin
            $display("FAIL abort_outputs: got %b expected 00000",
                     {bus.start_event, bus.window, bus.end_event, bus.busy, bus.done});
            n_errors++;
        end
        n_checks++;
        if (bus.win_cnt !== 8'd1) begin
            $display("FAIL abort_win_cnt: got %0d expected 1", bus.win_cnt);
            n_errors++;
        end
        seen_done = 1'b0;
        repeat (5) begin
            tick();
            seen_done = seen_done | bus.done | bus.busy;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            $display("FAIL abort_no_done: got %b expected 0", seen_done);
            n_errors++;
        end
        bus.win_len = 8'd1; bus.gap_len = 8'd0; bus.num_windows = 8'd2; bus.go = 1'b1;
        run_trace(10, 99, 0);
        n_checks++;
        if ({tr_s, tr_e} !== {mask(1, 1) | mask(4, 4), mask(3, 3) | mask(6, 6)}) begin
            $display("FAIL abort_rego_events: got %h/%h expected %h/%h", tr_s, tr_e,
                     mask(1, 1) | mask(4, 4), mask(3, 3) | mask(6, 6));
            n_errors++;
        end
        n_checks++;
        if ({tr_d, bus.win_cnt} !== {mask(7, 7), 8'd2}) begin
            $display("FAIL abort_rego_done: got %h/%0d expected %h/2", tr_d, bus.win_cnt,
                     mask(7, 7));
            n_errors++;
        end
    endtask

    task automatic test_enable_pause();
        bus.win_len = 8'd2; bus.gap_len = 8'd0; bus.num_windows = 8'd1;
        bus.inject_drop = 1'b0; bus.go = 1'b1;
        run_trace(12, 1, 3);
        n_checks++;
        if (tr_s !== mask(1, 4)) begin
            $display("FAIL pause_start: got %h expected %h", tr_s, mask(1, 4));
            n_errors++;
        end
        n_checks++;
        if (tr_w !== mask(5, 7)) begin
            $display("FAIL pause_window: got %h expected %h", tr_w, mask(5, 7));
            n_errors++;
        end
        n_checks++;
        if ({tr_e, tr_d, tr_b} !== {mask(7, 7), mask(8, 8), mask(1, 7)}) begin
            $display("FAIL pause_end_done_busy: got %h/%h/%h expected %h/%h/%h", tr_e, tr_d,
                     tr_b, mask(7, 7), mask(8, 8), mask(1, 7));
            n_errors++;
        end
    endtask

    task automatic test_zero_windows();
        bus.win_len = 8'd3; bus.gap_len = 8'd0; bus.num_windows = 8'd0;
        bus.inject_drop = 1'b0; bus.go = 1'b1;
        run_trace(5, 99, 0);
        n_checks++;
        if (tr_d !== mask(1, 1)) begin
            $display("FAIL zero_done: got %h expected %h", tr_d, mask(1, 1));
            n_errors++;
        end
        n_checks++;
        if ((tr_b | tr_s | tr_w | tr_e) !== 32'h0) begin
            $display("FAIL zero_quiet: got %h expected 0", tr_b | tr_s | tr_w | tr_e);
            n_errors++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_err = 0;
        chk_in = 1'b0;
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.go = 1'b0;
        bus.abort = 1'b0;
        bus.win_len = '0;
        bus.gap_len = '0;
        bus.num_windows = '0;
        bus.inject_drop = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_drop();
        test_abort();
        test_enable_pause();
        test_zero_windows();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
